scan_frame_decoder: RTL and testbench
=====================================

# scan_frame_decoder

Receive-side decoder for the 4x4 multiplexed LED scan bus driven by the binary-clock display driver. Samples the 8 scan pins (`{rows, cols}`), checks the row-scan sequence, and reassembles the 16-bit pixel frame. Decodes the hours and minutes fields from each frame. Used as a loopback checker in the test harness and as the front end of a companion board that mirrors the clock display.

## Interface
Parameters:
- `LOCK_FRAMES`, default 2: number of consecutive complete, well-formed frames required before `locked` asserts (range 1..15).

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: **synchronous, active-high reset.**
- `pins` input 8: scan bus. `[7:4]` is rows, active-low one-hot. `[3:0]` is cols, active-high pixel bits.
- `frame` output 16: last accepted frame, `[row*4+col]`.
- `hours` output 5: `frame[10:6]` of the last accepted frame.
- `minutes` output 6: `frame[5:0]` of the last accepted frame.
- `frame_valid` output 1: one-cycle pulse when `frame`, `hours` and `minutes` update.
- `locked` output 1: high once `LOCK_FRAMES` consecutive good frames have been received.
- `seq_err` output 1: one-cycle pulse on a row-sequence error.
- `fmt_err` output 1: one-cycle pulse when a complete frame fails the format check.
- `err_cnt` output 8: saturating error count (see Configuration).

## Operation
- **Input stage.** `pins` is registered once as `pins_q`. All decoding uses `pins_q`.
- **Row decode.** The rows field maps to a row index as follows:
  - `1110` → 0, `1101` → 1, `1011` → 2, `0111` → 3.
  - `0000` is IDLE (the transmitter is in reset).
  - Any other value is INVALID.
- **State machine** (states HUNT, RECV):
  - **HUNT:**
    - Row 0: capture cols into `buf[3:0]`, set expected row = 1, go to RECV.
    - Rows 1–3, IDLE or INVALID: ignore, with no error.
  - **RECV:**
    - Row equal to expected (1 or 2): capture cols into `buf[4*idx+3:4*idx]`, increment expected row.
    - Row 3 when expected: capture, complete the frame, then go to HUNT, or go directly to RECV with expected = 1 if the next sample is row 0 (see Timing).
    - IDLE: drop the partial frame, go to HUNT, clear `locked` and the good-frame count. No error.
    - INVALID or an unexpected row index: pulse `seq_err`, drop the partial frame, clear `locked` and the good-frame count.
      - Go to HUNT.
      - If the offending sample is row 0, instead treat it as a new frame start: capture it and set expected = 1.
- **Format check on a complete frame.** Any of the following is a format error:
  - `frame[15:11] != 0`
  - `hours > 23`
  - `minutes > 59`
- **Good frame:** update `frame`/`hours`/`minutes`, pulse `frame_valid`, increment the good-frame count (saturating at `LOCK_FRAMES`). Set `locked` when the count reaches `LOCK_FRAMES`.
- **Format error:** pulse `fmt_err`. `frame`/`hours`/`minutes` hold their previous values. Clear `locked` and the good-frame count.
- `seq_err` and `fmt_err` are mutually exclusive within a cycle.

## Timing
- **Reset values** (next edge after `rst` high):
  - `pins_q = 8'h00`, state = HUNT, buffer = 0, good-frame count = 0.
  - `frame = 0`, `hours = 0`, `minutes = 0`.
  - `frame_valid = 0`, `locked = 0`, `seq_err = 0`, `fmt_err = 0`, `err_cnt = 0`.
- `rst` dominates all other activity. Asserting reset mid-frame discards the partial frame.
- **Latency.** The row-3 pattern is present on `pins` at edge k and registered into `pins_q`. On edge k+1, `frame`, `hours`, `minutes` and `locked` update, and `frame_valid` or `fmt_err` is high for the cycle after edge k+1.
- `seq_err` follows the same one-cycle latency as `frame_valid`.
- **Back-to-back frames:** row 0 immediately after row 3 starts the next frame, with no dead cycle. One row is sampled per `clk`, matching the transmitter's rate of one row per clock.

## Configuration
- **`SCAN_DEC_ERRCNT_EN` defined:**
  - `err_cnt` is an 8-bit counter, incremented by 1 on each `seq_err` or `fmt_err` pulse.
  - It saturates at 255 and is cleared only by `rst`.
- **`SCAN_DEC_ERRCNT_EN` undefined:** `err_cnt` is tied to `8'h00` and no counter flops are present. All other behaviour is identical.

## Test plan
1. **Clean frames.** After reset, drive `pins` = `ED, D6, B3, 70` twice (hours 13, minutes 45).
   - Each frame produces `frame_valid` with `frame = 16'h036D`, `hours = 13`, `minutes = 45`.
   - `locked` rises on the second `frame_valid`. `seq_err`, `fmt_err` and `err_cnt` stay 0.
2. **Skipped row.** While locked, drive `ED, D6, 70`.
   - `seq_err` pulses and `locked` goes to 0.
   - No `frame_valid`; `frame` holds `036D`.
   - `err_cnt = 1` with the macro, 0 without.
3. **Bad hours.** Drive `E0, D0, B6, 70` (pixels `0600`, hours 24).
   - `fmt_err` pulses. No `frame_valid`; `hours`/`minutes` hold 13/45.
   - `err_cnt` increments.
4. **Idle mid-frame.** Drive `ED, D6, 00`, then two clean frames.
   - No error on the `00` sample, and `locked` clears.
   - The following two clean frames re-lock.
5. **Reset mid-frame and late start.**
   - Assert `rst` during row 2: all outputs are 0 at the next edge.
   - Release reset, then start the stream at row 2 (`B3, 70`): ignored, with no error.
   - The next full frame gives `frame_valid` with `036D`.
6. **Error counter saturation** (macro defined). Apply 300 `seq_err` events: `err_cnt` stops at 255.

Source files
------------

// File: rtl/scan_frame_decoder.sv
// Receive-side decoder for the 4x4 multiplexed LED scan bus.
// Registers the scan pins, follows the row-scan sequence, rebuilds the
// 16-bit frame and splits out the hours/minutes fields.
// Optional feature macro: SCAN_DEC_ERRCNT_EN (saturating error counter).
module scan_frame_decoder #(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pins,
  output logic [15:0] frame,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic        frame_valid,
  output logic        locked,
  output logic        seq_err,
  output logic        fmt_err,
  output logic [7:0]  err_cnt
);

  localparam logic [3:0] LockCnt = 4'(LOCK_FRAMES);

  typedef enum logic {StHunt, StRecv} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pins_q;
  logic [11:0] buf_q, buf_d;       // rows 0..2; row 3 comes straight from cols
  logic [1:0]  exp_q, exp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        locked_q, locked_d;
  logic [15:0] frame_q, frame_d;
  logic        valid_q, valid_d;
  logic        seq_q, seq_d;
  logic        fmt_q, fmt_d;

  logic [3:0]  rows, cols;
  logic        row_vld, row_idle;
  logic [1:0]  row_idx;
  logic [15:0] full;
  logic        fmt_bad;

  assign rows = pins_q[7:4];
  assign cols = pins_q[3:0];
  assign full = {cols, buf_q};
  assign fmt_bad = (full[15:11] != 5'd0) || (full[10:6] > 5'd23) || (full[5:0] > 6'd59);

  // Decode the active-low one-hot rows field into an index.
  always_comb begin
    row_vld  = 1'b1;
    row_idx  = 2'd0;
    row_idle = (rows == 4'b0000);
    case (rows)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_vld = 1'b0;
    endcase
  end

  // Sequence tracking, frame assembly and format check.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    frame_d  = frame_q;
    valid_d  = 1'b0;
    seq_d    = 1'b0;
    fmt_d    = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (row_vld && row_idx == 2'd0) begin
          buf_d   = {8'h00, cols};
          exp_d   = 2'd1;
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (row_idle) begin
          state_d  = StHunt;
          cnt_d    = 4'd0;
          locked_d = 1'b0;
        end else if (row_vld && row_idx == exp_q) begin
          case (exp_q)
            2'd1:    buf_d[7:4]  = cols;
            2'd2:    buf_d[11:8] = cols;
            default: ;
          endcase
          if (exp_q == 2'd3) begin
            // Return to HUNT; a following row 0 starts the next frame at once.
            state_d = StHunt;
            if (fmt_bad) begin
              fmt_d    = 1'b1;
              cnt_d    = 4'd0;
              locked_d = 1'b0;
            end else begin
              frame_d  = full;
              valid_d  = 1'b1;
              cnt_d    = (cnt_q < LockCnt) ? cnt_q + 4'd1 : cnt_q;
              locked_d = (cnt_d == LockCnt);
            end
          end else begin
            exp_d = exp_q + 2'd1;
          end
        end else begin
          seq_d    = 1'b1;
          cnt_d    = 4'd0;
          locked_d = 1'b0;
          // An out-of-place row 0 is taken as the start of a fresh frame.
          if (row_vld && row_idx == 2'd0) begin
            buf_d = {8'h00, cols};
            exp_d = 2'd1;
          end else begin
            state_d = StHunt;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHunt;
      pins_q   <= 8'h00;
      buf_q    <= 12'h000;
      exp_q    <= 2'd0;
      cnt_q    <= 4'd0;
      locked_q <= 1'b0;
      frame_q  <= 16'h0000;
      valid_q  <= 1'b0;
      seq_q    <= 1'b0;
      fmt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pins_q   <= pins;
      buf_q    <= buf_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      seq_q    <= seq_d;
      fmt_q    <= fmt_d;
    end
  end

`ifdef SCAN_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count every error pulse, saturating at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((seq_d || fmt_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign frame       = frame_q;
  assign hours       = frame_q[10:6];
  assign minutes     = frame_q[5:0];
  assign frame_valid = valid_q;
  assign locked      = locked_q;
  assign seq_err     = seq_q;
  assign fmt_err     = fmt_q;

endmodule

// File: tb/tb_scan_frame_decoder.sv
// Scoreboard bench for scan_frame_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares whenever an output pulse appears.
module tb_scan_frame_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pins = 8'h00;
  logic [15:0] frame;
  logic [4:0]  hours;
  logic [5:0]  minutes;
  logic        frame_valid, locked, seq_err, fmt_err;
  logic [7:0]  err_cnt;

  scan_frame_decoder #(.LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .pins(pins), .frame(frame), .hours(hours),
    .minutes(minutes), .frame_valid(frame_valid), .locked(locked),
    .seq_err(seq_err), .fmt_err(fmt_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  pulses;  // {frame_valid, seq_err, fmt_err}
    logic [15:0] frm;
    logic [4:0]  hr;
    logic [5:0]  mn;
    logic        lck;
    logic [7:0]  ec;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Queue an expected pulse; error kinds bump the bench's error count.
  task automatic push(input logic [2:0] p, input logic [15:0] f, input logic [4:0] h,
                      input logic [5:0] m, input logic l);
    exp_t e;
`ifdef SCAN_DEC_ERRCNT_EN
    if (p != 3'b100 && exp_err < 255) exp_err++;
`endif
    e.pulses = p; e.frm = f; e.hr = h; e.mn = m; e.lck = l; e.ec = 8'(exp_err);
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] v);
    pins = v;
    @(posedge clk);
    #1;
  endtask

  task automatic clean_frame(input logic lck_after);
    send(8'hED); send(8'hD6); send(8'hB3);
    push(3'b100, 16'h036D, 5'd13, 6'd45, lck_after);
    send(8'h70);
  endtask

  // Monitor: compare every output pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (frame_valid || seq_err || fmt_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, frame_valid, seq_err, fmt_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulses", {29'd0, frame_valid, seq_err, fmt_err}, {29'd0, e.pulses});
        chk("frame", {16'd0, frame}, {16'd0, e.frm});
        chk("hours", {27'd0, hours}, {27'd0, e.hr});
        chk("minutes", {26'd0, minutes}, {26'd0, e.mn});
        chk("locked", {31'd0, locked}, {31'd0, e.lck});
        chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.ec});
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_frame"}, {16'd0, frame}, 32'd0);
    chk({nm, "_flags"}, {28'd0, frame_valid, locked, seq_err, fmt_err}, 32'd0);
    chk({nm, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
  endtask

  initial begin
    // Reset state.
    @(posedge clk); #1;
    chk_all_zero("reset");
    rst = 1'b0;
    send(8'h00);

    // 1. Two clean frames, lock on the second.
    clean_frame(1'b0);
    clean_frame(1'b1);
    send(8'h00);
    send(8'h00);
    chk("t1_locked", {31'd0, locked}, 32'd1);

    // 2. Skipped row while locked.
    send(8'hED); send(8'hD6);
    push(3'b010, 16'h036D, 5'd13, 6'd45, 1'b0);
    send(8'h70);
    send(8'h00);

    // 3. Hours out of range.
    send(8'hE0); send(8'hD0); send(8'hB6);
    push(3'b001, 16'h036D, 5'd13, 6'd45, 1'b0);
    send(8'h70);
    send(8'h00);

    // 4. Idle mid-frame clears lock silently, then re-lock.
    clean_frame(1'b0);
    clean_frame(1'b1);
    send(8'hED); send(8'hD6); send(8'h00);
    send(8'h00);
    chk("t4_unlocked", {31'd0, locked}, 32'd0);
    clean_frame(1'b0);
    clean_frame(1'b1);
    send(8'h00);

    // 5. Reset during row 2, then a late start at row 2.
    send(8'hED); send(8'hD6);
    pins = 8'hB3;
    rst  = 1'b1;
    exp_err = 0;
    @(posedge clk); #1;
    chk_all_zero("t5_reset");
    rst = 1'b0;
    send(8'hB3); send(8'h70); send(8'h00);
    chk("t5_late_start_frame", {16'd0, frame}, 32'd0);
    clean_frame(1'b0);
    send(8'h00);

`ifdef SCAN_DEC_ERRCNT_EN
    // 6. Repeated row 0 in RECV: one seq_err per sample, counter saturates.
    send(8'hED);
    for (int i = 0; i < 300; i++) begin
      push(3'b010, 16'h036D, 5'd13, 6'd45, 1'b0);
      send(8'hED);
    end
    send(8'h00);
    send(8'h00);
    chk("t6_err_cnt_sat", {24'd0, err_cnt}, 32'd255);
`endif

    repeat (3) send(8'h00);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
